// File: rtl/uart_transmitter.sv
// UART serializer (start, DBITS data bits LSB first, optional parity, stop) paced by a 16x sample_tick.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd with PARITY_ODD = 1) between data and stop.
module uart_transmitter #(
  parameter int DBITS      = 8,
  parameter int SB_TICK    = 16,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_tick,
  input  logic             tx_start,
  input  logic [DBITS-1:0] data_in,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e           state_q;
  logic [4:0]       tickCnt_q;
  logic [4:0]       tickCnt_d;
  logic [2:0]       nbits_q;
  logic [DBITS-1:0] shiftReg_q;
  logic [DBITS-1:0] shiftReg_d;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
`ifdef UART_TX_PARITY_EN
  logic             parity_q;
`endif

  // The tick counter is five bits so the stop period can stretch to two bit times.
  always_comb begin
    tickCnt_d  = tickCnt_q + 5'd1;
    shiftReg_d = shiftReg_q >> 1;
  end

  // tx, tx_busy and tx_done are registered alongside the state so every output is glitch-free.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      tickCnt_q  <= '0;
      nbits_q    <= '0;
      shiftReg_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_q <= 1'b1;
          if (tx_start) begin
            shiftReg_q <= data_in;
            tickCnt_q  <= '0;
            nbits_q    <= '0;
            tx_q       <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= START;
`ifdef UART_TX_PARITY_EN
            parity_q   <= (^data_in) ^ PARITY_ODD;
`endif
          end
        end
        START: begin
          if (sample_tick) begin
            if (tickCnt_q == 5'd15) begin
              tickCnt_q <= '0;
              nbits_q   <= '0;
              tx_q      <= shiftReg_q[0];
              state_q   <= DATA;
            end else begin
              tickCnt_q <= tickCnt_d;
            end
          end
        end
        DATA: begin
          if (sample_tick) begin
            if (tickCnt_q == 5'd15) begin
              tickCnt_q  <= '0;
              shiftReg_q <= shiftReg_d;
              if (nbits_q == 3'(DBITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                tx_q    <= parity_q;
                state_q <= PARITY;
`else
                tx_q    <= 1'b1;
                state_q <= STOP;
`endif
              end else begin
                nbits_q <= nbits_q + 3'd1;
                tx_q    <= shiftReg_d[0];
              end
            end else begin
              tickCnt_q <= tickCnt_d;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (sample_tick) begin
            if (tickCnt_q == 5'd15) begin
              tickCnt_q <= '0;
              tx_q      <= 1'b1;
              state_q   <= STOP;
            end else begin
              tickCnt_q <= tickCnt_d;
            end
          end
        end
`endif
        STOP: begin
          tx_q <= 1'b1;
          if (sample_tick) begin
            if (tickCnt_q == 5'(SB_TICK - 1)) begin
              tickCnt_q <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= IDLE;
            end else begin
              tickCnt_q <= tickCnt_d;
            end
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter: checks every bit of each frame against hand-derived bit sequences.
// sample_tick pulses every 4 clocks, so a full bit lasts 64 clocks.
module tb_uart_transmitter;
  localparam bit PODD = 1'b0;

  logic       clk = 1'b0;
  logic       reset;
  logic       sample_tick;
  logic       tx_start;
  logic [7:0] data_in;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;
  int phase = 0;

  always #5 clk = ~clk;

  uart_transmitter #(
    .DBITS(8),
    .SB_TICK(16),
    .PARITY_ODD(PODD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_tick(sample_tick),
    .tx_start(tx_start),
    .data_in(data_in),
    .tx(tx),
    .tx_busy(tx_busy),
    .tx_done(tx_done)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, actual, expected);
    end
  endtask

  // Advances one clock; sample_tick is set up here for the following posedge.
  task automatic tickClock();
    @(negedge clk);
    phase = (phase + 1) % 4;
    sample_tick = (phase == 0);
  endtask

  // Caller raises tx_start with data_in = d at the current negedge while the DUT is idle.
  task automatic applyStimulus(input logic [7:0] d, input int injectBit, input int abortBit,
                               input bit chain, input logic [7:0] nextD, input string name);
    logic expBits[11];
    int   nb;
    int   anomalies;
    int   ticks;
    int   clks;
    int   wrong;
    expBits[0] = 1'b0;
    for (int i = 0; i < 8; i++) expBits[i+1] = d[i];
    nb = 9;
`ifdef UART_TX_PARITY_EN
    expBits[nb] = (^d) ^ PODD;
    nb++;
`endif
    expBits[nb] = 1'b1;
    nb++;

    tickClock();
    tx_start = 1'b0;
    data_in  = ~d;
    checkOutput($sformatf("%s_fall", name), tx, 0);
    checkOutput($sformatf("%s_busy", name), tx_busy, 1);

    anomalies = 0;
    for (int k = 0; k < nb; k++) begin
      ticks = 0;
      clks  = 0;
      wrong = 0;
      while (ticks < 16) begin
        if (tx !== expBits[k]) wrong++;
        if (tx_done !== 1'b0 || tx_busy !== 1'b1) anomalies++;
        if (k == abortBit && ticks == 8) begin
          reset = 1'b1;
          tickClock();
          reset = 1'b0;
          checkOutput($sformatf("%s_abort_tx", name), tx, 1);
          checkOutput($sformatf("%s_abort_busy", name), tx_busy, 0);
          checkOutput($sformatf("%s_abort_done", name), tx_done, 0);
          return;
        end
        if (k == injectBit) begin
          if (ticks == 8) begin
            tx_start = 1'b1;
            data_in  = 8'h3C;
          end else if (ticks == 10) begin
            tx_start = 1'b0;
            data_in  = ~d;
          end
        end
        if (sample_tick) ticks++;
        tickClock();
        clks++;
      end
      checkOutput($sformatf("%s_bit%0d", name, k), wrong, 0);
      if (k == 0)
        checkOutput($sformatf("%s_startlen", name), (clks >= 60 && clks <= 64), 1);
      else
        checkOutput($sformatf("%s_len%0d", name, k), clks, 64);
    end

    checkOutput($sformatf("%s_done", name), tx_done, 1);
    checkOutput($sformatf("%s_endbusy", name), tx_busy, 0);
    checkOutput($sformatf("%s_endtx", name), tx, 1);
    checkOutput($sformatf("%s_anomalies", name), anomalies, 0);
    if (chain) begin
      tx_start = 1'b1;
      data_in  = nextD;
    end else begin
      tickClock();
      checkOutput($sformatf("%s_donepulse", name), tx_done, 0);
    end
  endtask

  initial begin
    int idleBad;
    reset       = 1'b1;
    sample_tick = 1'b0;
    tx_start    = 1'b0;
    data_in     = 8'h00;
    repeat (3) tickClock();
    checkOutput("rst_tx", tx, 1);
    checkOutput("rst_busy", tx_busy, 0);
    checkOutput("rst_done", tx_done, 0);
    reset = 1'b0;

    idleBad = 0;
    for (int i = 0; i < 100; i++) begin
      tickClock();
      if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) idleBad++;
    end
    checkOutput("idle_bad", idleBad, 0);

    tx_start = 1'b1;
    data_in  = 8'hA5;
    applyStimulus(8'hA5, -1, -1, 1'b0, 8'h00, "a5");

    repeat (5) tickClock();
    tx_start = 1'b1;
    data_in  = 8'h55;
    applyStimulus(8'h55, 4, -1, 1'b0, 8'h00, "s55");

    repeat (3) tickClock();
    tx_start = 1'b1;
    data_in  = 8'hC3;
    applyStimulus(8'hC3, -1, -1, 1'b1, 8'h0F, "c3");
    applyStimulus(8'h0F, -1, -1, 1'b0, 8'h00, "b2b0f");

    repeat (2) tickClock();
    tx_start = 1'b1;
    data_in  = 8'hFF;
    applyStimulus(8'hFF, -1, 5, 1'b0, 8'h00, "ff");

    repeat (6) tickClock();
    tx_start = 1'b1;
    data_in  = 8'h81;
    applyStimulus(8'h81, -1, -1, 1'b0, 8'h00, "s81");

    repeat (7) tickClock();
    tx_start = 1'b1;
    data_in  = 8'h07;
    applyStimulus(8'h07, -1, -1, 1'b0, 8'h00, "s07");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
